cpld_bus_system: RTL and testbench
==================================

Name: cpld_bus_system

Overview:
- CPLD top-level bridging an AVR microcontroller, a 2M×8 SRAM and the SNES cartridge bus.
- The AVR loads a 21-bit SRAM address serially into a shift register, which doubles as an auto-increment address counter.
- The AVR then reads or writes SRAM bytes through a bus state machine with a registered data buffer.
- A control bit hands the SRAM bus to the SNES (address/data passthrough).

Parameters:
- ADDR_W, 21, SRAM/SNES address width
- DATA_W, 8, data bus width

Ports:
- avr_clk  in  1  system clock; all logic on rising edge
- avr_reset  in  1  asynchronous active-low reset
- avr_si  in  1  serial address bit, MSB first
- avr_sreg_en  in  1  active-low shift enable
- avr_counter  in  1  active-low address increment request
- avr_oe  in  1  active-low AVR read request
- avr_we  in  1  active-low AVR write request
- avr_ctrl  in  3  [0]=snes_mode, [1]=snes_data drive enable, [2] reserved (ignored)
- avr_data  inout  8  AVR data bus
- sram_addr  out  21  SRAM address
- sram_data  inout  8  SRAM data bus
- sram_ce_n  out  1  SRAM chip enable, active-low
- sram_oe_n  out  1  SRAM output enable, active-low
- sram_we_n  out  1  SRAM write enable, active-low
- snes_addr  in  21  SNES address
- snes_data  inout  8  SNES data bus

Behaviour:
Reset (avr_reset=0, asynchronous):
- addr register=0, state=IDLE, buffer=0.
- sram_ce_n, sram_oe_n and sram_we_n all 1.
- All inout buses Z.

Address register (21 bits):
- avr_sreg_en=0: addr <= {addr[19:0], avr_si} each edge. Increment is ignored while shifting.
- avr_sreg_en=1 and avr_counter=0: addr <= addr+1 each edge; 0x1FFFFF wraps to 0.
- Otherwise: hold.

Bus FSM states: IDLE, RD_SETUP, RD_HOLD, WR_SETUP, WR_STROBE, WR_END.
- FSM runs only when avr_ctrl[0]=0.
- Inputs avr_oe/avr_we are sampled on the rising edge.
- IDLE:
  - avr_oe=0 and avr_we=1 -> RD_SETUP.
  - avr_we=0 and avr_oe=1 -> WR_SETUP; buffer <= avr_data.
  - Both low or both high: stay in IDLE.
- RD_SETUP:
  - sram_ce_n=0, sram_oe_n=0.
  - Next edge -> RD_HOLD, buffer <= sram_data.
- RD_HOLD:
  - sram_ce_n=0, sram_oe_n=0, avr_data driven with buffer.
  - While avr_oe=0, buffer <= sram_data every edge, so avr_data follows SRAM with 1-cycle latency.
  - avr_oe=1 -> IDLE; avr_data goes Z.
- WR_SETUP:
  - sram_ce_n=0, sram_data driven with buffer, sram_we_n=1.
  - Next edge -> WR_STROBE.
- WR_STROBE:
  - sram_we_n=0, sram_data driven with buffer.
  - While avr_we=0, buffer <= avr_data every edge.
  - avr_we=1 -> WR_END.
- WR_END:
  - sram_we_n=1; sram_data and sram_ce_n held for one cycle (hold time).
  - Then -> IDLE.
- Bus drive rules:
  - sram_data is driven only in WR_* states.
  - avr_data is driven only in RD_HOLD.
  - sram_oe_n is never 0 in WR_* states.
- Outputs sram_ce_n, sram_oe_n, sram_we_n are registered (decoded from state register).
- sram_addr = addr in AVR mode.

SNES mode (avr_ctrl[0]=1):
- FSM is forced to IDLE.
- sram_addr = snes_addr.
- sram_ce_n=0, sram_oe_n=0, sram_we_n=1.
- snes_data driven with sram_data when avr_ctrl[1]=1, otherwise Z.
- avr_data is Z.
- Switching mode mid-transaction aborts it: next state IDLE, strobes deasserted on the next edge.

Decomposition:
- Shared package: ADDR_W and DATA_W constants, plus the bus FSM state enum (IDLE, RD_SETUP, RD_HOLD, WR_SETUP, WR_STROBE, WR_END).
- One sub-module, addr_shift_counter: the 21-bit shift/increment register, with ports clk, reset_n, si, en_n, inc_n and addr.
- The FSM, tristate control and SNES mux live in cpld_bus_system.

Test Plan:
- Reset: assert avr_reset=0 -> sram_addr=0; ce_n/oe_n/we_n=1; avr_data and sram_data Z.
- Shift: avr_sreg_en=0, clock in 21 bits of 0x1ABCDE MSB first -> sram_addr=0x1ABCDE. Holding avr_sreg_en=1 afterwards keeps it.
- Read: sram_data=0xAA, avr_oe=0 -> ce_n/oe_n=0 after edge 1, avr_data=0xAA after edge 2. Change sram_data to 0xBB -> avr_data=0xBB one edge later. avr_oe=1 -> avr_data Z, IDLE.
- Write: avr_we=0, avr_data=0xEE -> sram_data=0xEE, ce_n=0, we_n=0 from the second edge. avr_we=1 -> we_n=1, data held one cycle, then Z.
- Counter: addr=0x1FFFFE, avr_counter=0 for one cycle -> 0x1FFFFF; a second pulse -> 0x000000.
- SNES mode: avr_ctrl=3'b011, snes_addr=0x012345, sram_data=0x5A -> sram_addr=0x012345, snes_data=0x5A, avr_oe=0 ignored.

Source files
------------

// File: rtl/cpld_bus_system_pkg.sv
// rtl/cpld_bus_system_pkg.sv - shared widths and bus FSM state encoding
package cpld_bus_system_pkg;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_SETUP  = 3'd1,
        RD_HOLD   = 3'd2,
        WR_SETUP  = 3'd3,
        WR_STROBE = 3'd4,
        WR_END    = 3'd5
    } bus_state_e;

endpackage

// File: rtl/addr_shift_counter.sv
// rtl/addr_shift_counter.sv - serially loaded SRAM address register with auto-increment
module addr_shift_counter
    import cpld_bus_system_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              si,
    input  logic              en_n,
    input  logic              inc_n,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    // Shifting has priority over increment; increment wraps naturally at full scale
    always_comb begin
        addr_d = addr_q;
        if (!en_n) begin
            addr_d = {addr_q[ADDR_W-2:0], si};
        end else if (!inc_n) begin
            addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    // Address state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/cpld_bus_system.sv
// rtl/cpld_bus_system.sv - AVR/SRAM/SNES bus bridge top level
module cpld_bus_system
    import cpld_bus_system_pkg::*;
(
    input  logic              avr_clk,
    input  logic              avr_reset,
    input  logic              avr_si,
    input  logic              avr_sreg_en,
    input  logic              avr_counter,
    input  logic              avr_oe,
    input  logic              avr_we,
    input  logic [2:0]        avr_ctrl,
    inout  wire  [DATA_W-1:0] avr_data,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    input  logic [ADDR_W-1:0] snes_addr,
    inout  wire  [DATA_W-1:0] snes_data
);

    bus_state_e        state_q;
    logic [DATA_W-1:0] buf_q;
    logic              ce_n_q;
    logic              oe_n_q;
    logic              we_n_q;
    logic              avr_drv_q;
    logic              sram_drv_q;
    logic [ADDR_W-1:0] avr_addr;
    logic              snes_mode;
    logic              unused_ctrl;

    assign snes_mode   = avr_ctrl[0];
    assign unused_ctrl = avr_ctrl[2];

    addr_shift_counter u_addr (
        .clk     (avr_clk),
        .reset_n (avr_reset),
        .si      (avr_si),
        .en_n    (avr_sreg_en),
        .inc_n   (avr_counter),
        .addr    (avr_addr)
    );

    // Bus FSM: strobes and bus drive enables are registered from the next state
    always_ff @(posedge avr_clk or negedge avr_reset) begin
        if (!avr_reset) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            avr_drv_q  <= 1'b0;
            sram_drv_q <= 1'b0;
        end else if (snes_mode) begin
            // SNES owns the SRAM; any AVR transaction in flight is dropped
            state_q    <= IDLE;
            ce_n_q     <= 1'b0;
            oe_n_q     <= 1'b0;
            we_n_q     <= 1'b1;
            avr_drv_q  <= 1'b0;
            sram_drv_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!avr_oe && avr_we) begin
                        state_q    <= RD_SETUP;
                        ce_n_q     <= 1'b0;
                        oe_n_q     <= 1'b0;
                        we_n_q     <= 1'b1;
                        avr_drv_q  <= 1'b0;
                        sram_drv_q <= 1'b0;
                    end else if (!avr_we && avr_oe) begin
                        state_q    <= WR_SETUP;
                        buf_q      <= avr_data;
                        ce_n_q     <= 1'b0;
                        oe_n_q     <= 1'b1;
                        we_n_q     <= 1'b1;
                        avr_drv_q  <= 1'b0;
                        sram_drv_q <= 1'b1;
                    end else begin
                        ce_n_q     <= 1'b1;
                        oe_n_q     <= 1'b1;
                        we_n_q     <= 1'b1;
                        avr_drv_q  <= 1'b0;
                        sram_drv_q <= 1'b0;
                    end
                end
                RD_SETUP: begin
                    state_q   <= RD_HOLD;
                    buf_q     <= sram_data;
                    avr_drv_q <= 1'b1;
                end
                RD_HOLD: begin
                    if (!avr_oe) begin
                        buf_q <= sram_data;
                    end else begin
                        state_q   <= IDLE;
                        ce_n_q    <= 1'b1;
                        oe_n_q    <= 1'b1;
                        avr_drv_q <= 1'b0;
                    end
                end
                WR_SETUP: begin
                    state_q <= WR_STROBE;
                    we_n_q  <= 1'b0;
                end
                WR_STROBE: begin
                    if (!avr_we) begin
                        buf_q <= avr_data;
                    end else begin
                        state_q <= WR_END;
                        we_n_q  <= 1'b1;
                    end
                end
                WR_END: begin
                    // Data and chip enable were held one extra cycle for SRAM hold time
                    state_q    <= IDLE;
                    ce_n_q     <= 1'b1;
                    sram_drv_q <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    ce_n_q     <= 1'b1;
                    oe_n_q     <= 1'b1;
                    we_n_q     <= 1'b1;
                    avr_drv_q  <= 1'b0;
                    sram_drv_q <= 1'b0;
                end
            endcase
        end
    end

    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign sram_addr = snes_mode ? snes_addr : avr_addr;

    // Drive enables are also gated by mode so a mode switch releases the buses at once
    assign avr_data  = (avr_drv_q && !snes_mode)  ? buf_q     : {DATA_W{1'bz}};
    assign sram_data = (sram_drv_q && !snes_mode) ? buf_q     : {DATA_W{1'bz}};
    assign snes_data = (snes_mode && avr_ctrl[1]) ? sram_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_cpld_bus_system.sv
// tb/tb_cpld_bus_system.sv - directed vector bench for cpld_bus_system
module tb_cpld_bus_system;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        si;
    logic        sreg_en;
    logic        counter;
    logic        oe;
    logic        we;
    logic [2:0]  ctrl;
    logic [20:0] snes_addr;
    logic [20:0] sram_addr;
    logic        ce_n, oe_n, we_n;
    logic        avr_drv, sram_drv;
    logic [7:0]  avr_val, sram_val;

    // Undriven buses float high so a released bus reads 0xFF
    tri1 [7:0] avr_data;
    tri1 [7:0] sram_data;
    tri1 [7:0] snes_data;

    assign avr_data  = avr_drv  ? avr_val  : 8'hzz;
    assign sram_data = sram_drv ? sram_val : 8'hzz;

    int checks = 0;
    int errors = 0;

    localparam logic [20:0] A = 21'h1ABCDE;

    always #5 clk = ~clk;

    cpld_bus_system dut (
        .avr_clk     (clk),
        .avr_reset   (rst_n),
        .avr_si      (si),
        .avr_sreg_en (sreg_en),
        .avr_counter (counter),
        .avr_oe      (oe),
        .avr_we      (we),
        .avr_ctrl    (ctrl),
        .avr_data    (avr_data),
        .sram_addr   (sram_addr),
        .sram_data   (sram_data),
        .sram_ce_n   (ce_n),
        .sram_oe_n   (oe_n),
        .sram_we_n   (we_n),
        .snes_addr   (snes_addr),
        .snes_data   (snes_data)
    );

    typedef struct {
        string       name;
        logic        oe;
        logic        we;
        logic [2:0]  ctrl;
        logic [20:0] snes_addr;
        logic        avr_drv;
        logic [7:0]  avr_val;
        logic        sram_drv;
        logic [7:0]  sram_val;
        logic [20:0] e_addr;
        logic [2:0]  e_strb;
        logic [7:0]  e_avr;
        logic [7:0]  e_sram;
        logic [7:0]  e_snes;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic o, input logic w, input logic [2:0] c,
                       input logic [20:0] sa, input logic ad, input logic [7:0] av,
                       input logic sd, input logic [7:0] sv, input logic [20:0] ea,
                       input logic [2:0] es, input logic [7:0] eav, input logic [7:0] esr,
                       input logic [7:0] esn);
        vec_t v;
        v.name = nm; v.oe = o; v.we = w; v.ctrl = c; v.snes_addr = sa;
        v.avr_drv = ad; v.avr_val = av; v.sram_drv = sd; v.sram_val = sv;
        v.e_addr = ea; v.e_strb = es; v.e_avr = eav; v.e_sram = esr; v.e_snes = esn;
        vecs.push_back(v);
    endtask

    task automatic shift_in(input logic [20:0] v);
        for (int i = 20; i >= 0; i--) begin
            si      = v[i];
            sreg_en = 1'b0;
            @(posedge clk); #1;
        end
        sreg_en = 1'b1;
    endtask

    initial begin
        si = 0; sreg_en = 1; counter = 1; oe = 1; we = 1; ctrl = 3'b000;
        snes_addr = '0; avr_drv = 0; avr_val = '0; sram_drv = 0; sram_val = '0;
        rst_n = 0;

        // Expected strobes are {ce_n, oe_n, we_n}
        add("rd_setup",     0, 1, 3'b000, 21'h0,      0, 8'h00, 1, 8'hAA, A,         3'b001, 8'hFF, 8'hAA, 8'hFF);
        add("rd_hold_aa",   0, 1, 3'b000, 21'h0,      0, 8'h00, 1, 8'hAA, A,         3'b001, 8'hAA, 8'hAA, 8'hFF);
        add("rd_follow_bb", 0, 1, 3'b000, 21'h0,      0, 8'h00, 1, 8'hBB, A,         3'b001, 8'hBB, 8'hBB, 8'hFF);
        add("rd_end",       1, 1, 3'b000, 21'h0,      0, 8'h00, 1, 8'hBB, A,         3'b111, 8'hFF, 8'hBB, 8'hFF);
        add("both_low",     0, 0, 3'b000, 21'h0,      0, 8'h00, 0, 8'h00, A,         3'b111, 8'hFF, 8'hFF, 8'hFF);
        add("wr_setup",     1, 0, 3'b000, 21'h0,      1, 8'hEE, 0, 8'h00, A,         3'b011, 8'hEE, 8'hEE, 8'hFF);
        add("wr_strobe",    1, 0, 3'b000, 21'h0,      1, 8'hEE, 0, 8'h00, A,         3'b010, 8'hEE, 8'hEE, 8'hFF);
        add("wr_update",    1, 0, 3'b000, 21'h0,      1, 8'h11, 0, 8'h00, A,         3'b010, 8'h11, 8'h11, 8'hFF);
        add("wr_end",       1, 1, 3'b000, 21'h0,      0, 8'h00, 0, 8'h00, A,         3'b011, 8'hFF, 8'h11, 8'hFF);
        add("wr_idle",      1, 1, 3'b000, 21'h0,      0, 8'h00, 0, 8'h00, A,         3'b111, 8'hFF, 8'hFF, 8'hFF);
        add("snes_on",      0, 1, 3'b011, 21'h012345, 0, 8'h00, 1, 8'h5A, 21'h012345, 3'b001, 8'hFF, 8'h5A, 8'h5A);
        add("snes_oe_ign",  0, 1, 3'b011, 21'h012345, 0, 8'h00, 1, 8'h5A, 21'h012345, 3'b001, 8'hFF, 8'h5A, 8'h5A);
        add("snes_no_drv",  1, 1, 3'b001, 21'h012345, 0, 8'h00, 1, 8'h5A, 21'h012345, 3'b001, 8'hFF, 8'h5A, 8'hFF);
        add("snes_off",     1, 1, 3'b000, 21'h012345, 0, 8'h00, 0, 8'h00, A,         3'b111, 8'hFF, 8'hFF, 8'hFF);
        add("abort_setup",  1, 0, 3'b000, 21'h0,      1, 8'h33, 0, 8'h00, A,         3'b011, 8'h33, 8'h33, 8'hFF);
        add("abort_snes",   1, 0, 3'b001, 21'h0,      0, 8'h00, 0, 8'h00, 21'h0,     3'b001, 8'hFF, 8'hFF, 8'hFF);
        add("abort_idle",   1, 1, 3'b000, 21'h0,      0, 8'h00, 0, 8'h00, A,         3'b111, 8'hFF, 8'hFF, 8'hFF);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_addr", sram_addr, 21'h0);
        chk("reset_strb", {ce_n, oe_n, we_n}, 3'b111);
        chk("reset_avr_z", avr_data, 8'hFF);
        chk("reset_sram_z", sram_data, 8'hFF);
        chk("reset_snes_z", snes_data, 8'hFF);
        rst_n = 1;

        // Increment request held low throughout must be ignored while shifting
        counter = 0;
        shift_in(A);
        counter = 1;
        chk("shift_load", sram_addr, A);
        repeat (3) @(posedge clk);
        #1;
        chk("shift_hold", sram_addr, A);

        foreach (vecs[i]) begin
            oe = vecs[i].oe; we = vecs[i].we; ctrl = vecs[i].ctrl;
            snes_addr = vecs[i].snes_addr;
            avr_drv = vecs[i].avr_drv; avr_val = vecs[i].avr_val;
            sram_drv = vecs[i].sram_drv; sram_val = vecs[i].sram_val;
            @(posedge clk); #1;
            chk({vecs[i].name, "_addr"}, sram_addr, vecs[i].e_addr);
            chk({vecs[i].name, "_strb"}, {ce_n, oe_n, we_n}, vecs[i].e_strb);
            chk({vecs[i].name, "_avr"}, avr_data, vecs[i].e_avr);
            chk({vecs[i].name, "_sram"}, sram_data, vecs[i].e_sram);
            chk({vecs[i].name, "_snes"}, snes_data, vecs[i].e_snes);
        end

        shift_in(21'h1FFFFE);
        chk("cnt_load", sram_addr, 21'h1FFFFE);
        counter = 0;
        @(posedge clk); #1;
        counter = 1;
        chk("cnt_max", sram_addr, 21'h1FFFFF);
        @(posedge clk); #1;
        chk("cnt_hold", sram_addr, 21'h1FFFFF);
        counter = 0;
        @(posedge clk); #1;
        counter = 1;
        chk("cnt_wrap", sram_addr, 21'h000000);

        // Asynchronous reset in the middle of a write strobe
        we = 0; avr_drv = 1; avr_val = 8'h77;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_wr_strb", {ce_n, oe_n, we_n}, 3'b010);
        chk("mid_wr_data", sram_data, 8'h77);
        #2;
        rst_n = 0;
        #1;
        chk("async_rst_strb", {ce_n, oe_n, we_n}, 3'b111);
        chk("async_rst_sram_z", sram_data, 8'hFF);
        we = 1; avr_drv = 0;
        #1;
        rst_n = 1;
        @(posedge clk); #1;
        chk("post_rst_idle", {ce_n, oe_n, we_n}, 3'b111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
